// File: rtl/video_timing_gen_if.sv
// Bundle of pixel-advance enable and registered raster timing outputs.
// The timing generator is the master; a video consumer uses the slave side.
interface video_timing_gen_if #(
  parameter int CNT_W   = 10,
  parameter int FRAME_W = 8
) ();
  // pix_en qualifies each clock. The raster advances one pixel only on clocks where
  // pix_en=1. Every output describes the pixel now shown on hpos/vpos.
  logic               pix_en;
  logic [CNT_W-1:0]   hpos;
  logic [CNT_W-1:0]   vpos;
  logic               hsync;
  logic               vsync;
  logic               display_on;
  logic               hblank;
  logic               vblank;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  pix_en,
    output hpos, vpos, hsync, vsync, display_on, hblank, vblank,
           line_start, frame_start, frame_count
  );

  modport slave (
    output pix_en,
    input  hpos, vpos, hsync, vsync, display_on, hblank, vblank,
           line_start, frame_start, frame_count
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with sync, blanking and strobes
// registered on the same edge as the position they describe.
module video_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_BOTTOM  = 10,
  parameter int V_SYNC    = 2,
  parameter int V_TOP     = 33,
  parameter int CNT_W     = 10,
  parameter int FRAME_W   = 8,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1
) (
  input logic                clk,
  input logic                reset,
  video_timing_gen_if.master vt
);
  localparam int     H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int     V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam longint CNT_MAX = (64'sd1 <<< CNT_W) - 64'sd1;

  localparam bit PARAMS_BAD =
    (H_DISPLAY <= 0) || (H_FRONT <= 0) || (H_SYNC <= 0) || (H_BACK <= 0) ||
    (V_DISPLAY <= 0) || (V_BOTTOM <= 0) || (V_SYNC <= 0) || (V_TOP <= 0) ||
    (CNT_W <= 0) || (FRAME_W <= 0) ||
    (longint'(H_TOTAL - 1) > CNT_MAX) || (longint'(V_TOTAL - 1) > CNT_MAX);

  generate
    if (PARAMS_BAD) begin : g_param_check
      $error("video_timing_gen: zero parameter or totals do not fit in CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_BOTTOM);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             hblank_next;
  logic             vblank_next;
  logic             hs_active;
  logic             vs_active;

  // Flags are decoded from the next position so they land together with it.
  always_comb begin
    h_wrap      = (vt.hpos == H_LAST);
    v_wrap      = (vt.vpos == V_LAST);
    h_next      = h_wrap ? '0 : vt.hpos + CNT_W'(1);
    v_next      = vt.vpos;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : vt.vpos + CNT_W'(1);
    end
    hblank_next = (h_next >= H_VIS);
    vblank_next = (v_next >= V_VIS);
    hs_active   = (h_next >= HS_FIRST) && (h_next <= HS_LAST);
    vs_active   = (v_next >= VS_FIRST) && (v_next <= VS_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vt.hpos        <= H_LAST;
      vt.vpos        <= V_LAST;
      vt.frame_count <= '1;
      vt.hsync       <= ~HS_POL;
      vt.vsync       <= ~VS_POL;
      vt.display_on  <= 1'b0;
      vt.hblank      <= 1'b1;
      vt.vblank      <= 1'b1;
      vt.line_start  <= 1'b0;
      vt.frame_start <= 1'b0;
    end else begin
      vt.line_start  <= 1'b0;
      vt.frame_start <= 1'b0;
      if (vt.pix_en) begin
        vt.hpos        <= h_next;
        vt.vpos        <= v_next;
        vt.hsync       <= hs_active ? HS_POL : ~HS_POL;
        vt.vsync       <= vs_active ? VS_POL : ~VS_POL;
        vt.hblank      <= hblank_next;
        vt.vblank      <= vblank_next;
        vt.display_on  <= !hblank_next && !vblank_next;
        vt.line_start  <= h_wrap;
        vt.frame_start <= h_wrap && v_wrap;
        if (h_wrap && v_wrap) begin
          vt.frame_count <= vt.frame_count + FRAME_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// Three timing generator configurations driven by shared reset/pix_en and
// compared each clock against an arithmetic raster model.
module tb_video_timing_gen;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  video_timing_gen_if #(.CNT_W(10), .FRAME_W(8)) if_d ();
  video_timing_gen_if #(.CNT_W(6),  .FRAME_W(4)) if_m ();
  video_timing_gen_if #(.CNT_W(3),  .FRAME_W(2)) if_s ();

  video_timing_gen #(.HS_POL(1'b0)) dut_d (.clk(clk), .reset(reset), .vt(if_d));

  video_timing_gen #(
    .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_DISPLAY(12), .V_BOTTOM(3), .V_SYNC(2), .V_TOP(4),
    .CNT_W(6), .FRAME_W(4), .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut_m (.clk(clk), .reset(reset), .vt(if_m));

  video_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_DISPLAY(3), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(1),
    .CNT_W(3), .FRAME_W(2)
  ) dut_s (.clk(clk), .reset(reset), .vt(if_s));

  // hd hf hs hb vd vb vs vt fw hpol vpol
  int cfg [3][11] = '{
    '{640, 16, 96, 48, 480, 10, 2, 33, 8, 0, 1},
    '{16,  4,  6,  6,  12,  3,  2, 4,  4, 1, 0},
    '{4,   1,  1,  1,  3,   1,  1, 1,  2, 1, 1}
  };
  string dname [3]  = '{"def", "med", "small"};
  string fname [10] = '{"hpos", "vpos", "hsync", "vsync", "display_on",
                        "hblank", "vblank", "line_start", "frame_start", "frame_count"};

  int     checks = 0;
  int     errors = 0;
  int     cycle  = 0;
  longint n      = 0;
  bit     adv    = 1'b0;
  int     last_ls     = -1;
  bit     track_line  = 1'b0;
  longint last_fs_n   = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void get_obs(input int k, output logic [63:0] o [10]);
    case (k)
      0: o = '{64'(if_d.hpos), 64'(if_d.vpos), 64'(if_d.hsync), 64'(if_d.vsync),
               64'(if_d.display_on), 64'(if_d.hblank), 64'(if_d.vblank),
               64'(if_d.line_start), 64'(if_d.frame_start), 64'(if_d.frame_count)};
      1: o = '{64'(if_m.hpos), 64'(if_m.vpos), 64'(if_m.hsync), 64'(if_m.vsync),
               64'(if_m.display_on), 64'(if_m.hblank), 64'(if_m.vblank),
               64'(if_m.line_start), 64'(if_m.frame_start), 64'(if_m.frame_count)};
      default: o = '{64'(if_s.hpos), 64'(if_s.vpos), 64'(if_s.hsync), 64'(if_s.vsync),
               64'(if_s.display_on), 64'(if_s.hblank), 64'(if_s.vblank),
               64'(if_s.line_start), 64'(if_s.frame_start), 64'(if_s.frame_count)};
    endcase
  endfunction

  // Position is simply the (nn-1)-th pixel of the raster since the last reset.
  function automatic void model(input int k, input longint nn, input bit a,
                                output logic [63:0] e [10]);
    longint ht, vtot, tot, p, fr, h, v;
    ht   = cfg[k][0] + cfg[k][1] + cfg[k][2] + cfg[k][3];
    vtot = cfg[k][4] + cfg[k][5] + cfg[k][6] + cfg[k][7];
    tot  = ht * vtot;
    if (nn == 0) begin
      p  = tot - 1;
      fr = (64'sd1 <<< cfg[k][8]) - 1;
    end else begin
      p  = (nn - 1) % tot;
      fr = ((nn - 1) / tot) % (64'sd1 <<< cfg[k][8]);
    end
    h = p % ht;
    v = p / ht;
    e[0] = h;
    e[1] = v;
    e[2] = ((h >= cfg[k][0] + cfg[k][1]) && (h < cfg[k][0] + cfg[k][1] + cfg[k][2]))
           ? 64'(cfg[k][9]) : 64'(1 - cfg[k][9]);
    e[3] = ((v >= cfg[k][4] + cfg[k][5]) && (v < cfg[k][4] + cfg[k][5] + cfg[k][6]))
           ? 64'(cfg[k][10]) : 64'(1 - cfg[k][10]);
    e[4] = 64'((h < cfg[k][0]) && (v < cfg[k][4]));
    e[5] = 64'(h >= cfg[k][0]);
    e[6] = 64'(v >= cfg[k][4]);
    e[7] = 64'(a && (h == 0));
    e[8] = 64'(a && (p == 0));
    e[9] = fr;
  endfunction

  task automatic step(input bit r, input bit en);
    logic [63:0] o [10];
    logic [63:0] e [10];
    reset       = r;
    if_d.pix_en = en;
    if_m.pix_en = en;
    if_s.pix_en = en;
    @(posedge clk);
    if (r) begin
      n   = 0;
      adv = 1'b0;
      last_fs_n = -1;
    end else begin
      adv = en;
      if (en) n++;
    end
    @(negedge clk);
    cycle++;
    for (int k = 0; k < 3; k++) begin
      get_obs(k, o);
      model(k, n, adv, e);
      for (int f = 0; f < 10; f++)
        check($sformatf("%s.%s@%0d", dname[k], fname[f], cycle), o[f], e[f]);
    end
    if (track_line && if_d.line_start === 1'b1) begin
      if (last_ls >= 0) check($sformatf("def.line_period@%0d", cycle), 64'(cycle - last_ls), 64'd1600);
      last_ls = cycle;
    end
    if (if_s.frame_start === 1'b1) begin
      if (last_fs_n >= 0) check($sformatf("small.frame_len@%0d", cycle), 64'(n - last_fs_n), 64'd42);
      last_fs_n = n;
    end
  endtask

  initial begin
    reset       = 1'b1;
    if_d.pix_en = 1'b0;
    if_m.pix_en = 1'b0;
    if_s.pix_en = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'(i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    track_line = 1'b1;
    for (int i = 0; i < 3400; i++) step(1'b0, 1'(i % 2 == 0));
    track_line = 1'b0;
    for (int i = 0; i < 4000; i++)
      step(1'($urandom_range(0, 999) == 0), 1'($urandom_range(0, 3) != 0));
    step(1'b1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 50; i++) step(1'b0, 1'($urandom_range(0, 1)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640: visible pixels per line.
REQ-002 Parameter H_FRONT, default 16: horizontal front porch (pixels after display, before sync).
REQ-003 Parameter H_SYNC, default 96: hsync width in pixels.
REQ-004 Parameter H_BACK, default 48: horizontal back porch (pixels after sync).
REQ-005 Parameter V_DISPLAY, default 480: visible lines per frame.
REQ-006 Parameter V_BOTTOM, default 10: vertical front porch in lines (after display, before sync).
REQ-007 Parameter V_SYNC, default 2: vsync width in lines.
REQ-008 Parameter V_TOP, default 33: vertical back porch in lines.
REQ-009 Parameter CNT_W, default 10: width of hpos/vpos.
REQ-010 Parameter FRAME_W, default 8: width of frame_count.
REQ-011 Parameter HS_POL, default 1: hsync active level.
REQ-012 Parameter VS_POL, default 1: vsync active level.
REQ-013 clk  input  1  single clock; all state changes on rising edge.
REQ-014 reset  input  1  synchronous, active-high.
REQ-015 pix_en  input  1  pixel advance enable; timing advances only on clocks where pix_en=1.
REQ-016 hpos  output  CNT_W  current pixel column.
REQ-017 vpos  output  CNT_W  current line.
REQ-018 hsync, vsync  output  1 each  sync outputs at configured polarity.
REQ-019 display_on  output  1  current pixel is visible.
REQ-020 hblank, vblank  output  1 each  current column / line outside visible area.
REQ-021 line_start, frame_start  output  1 each  single-clock strobes.
REQ-022 frame_count  output  FRAME_W  frame index.

Function
REQ-023 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL = V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP.
REQ-024 Elaboration SHALL fail if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CNT_W-1, or if any parameter is 0.
REQ-025 All outputs SHALL be registers updated on the same edge as hpos/vpos; every flag describes the pixel currently shown on hpos/vpos (zero latency between position and flags).
REQ-026 pix_en=1: hpos increments; hpos=H_TOTAL-1 wraps to 0 and vpos increments; vpos=V_TOTAL-1 with hpos wrap wraps vpos to 0.
REQ-027 pix_en=0: hpos, vpos, hsync, vsync, display_on, hblank, vblank, frame_count hold; line_start and frame_start SHALL be 0.
REQ-028 hsync active iff H_DISPLAY+H_FRONT <= hpos <= H_DISPLAY+H_FRONT+H_SYNC-1; otherwise ~HS_POL.
REQ-029 vsync active iff V_DISPLAY+V_BOTTOM <= vpos <= V_DISPLAY+V_BOTTOM+V_SYNC-1, for the whole line; otherwise ~VS_POL.
REQ-030 hblank = (hpos >= H_DISPLAY); vblank = (vpos >= V_DISPLAY); display_on = !hblank && !vblank.
REQ-031 line_start = 1 for exactly the clock on which hpos became 0 via a pix_en advance.
REQ-032 frame_start = 1 for exactly the clock on which (hpos,vpos) became (0,0) via a pix_en advance; line_start also 1 then.
REQ-033 frame_count increments by 1 on each frame_start edge, wrapping modulo 2^FRAME_W.
REQ-034 Counters SHALL never take values >= H_TOTAL / V_TOTAL.

Reset
REQ-035 While reset=1 (sampled at edge), regardless of pix_en: hpos=H_TOTAL-1, vpos=V_TOTAL-1, frame_count=all ones, hsync=~HS_POL, vsync=~VS_POL, display_on=0, hblank=1, vblank=1, line_start=0, frame_start=0.
REQ-036 Reset overrides pix_en and is effective at any position mid-line or mid-frame; the first pix_en advance after release lands on (0,0) with frame_start=1 and frame_count=0.

Verification
REQ-037 Defaults, reset 3 clocks then pix_en=1 -> first edge: hpos=0, vpos=0, frame_start=1, line_start=1, display_on=1, frame_count=0; next frame_start 420000 clocks later with frame_count=1.
REQ-038 Defaults, HS_POL=0 -> hsync low exactly hpos 656..751 (96 clocks/line), high elsewhere; hblank 1 for hpos 640..799.
REQ-039 Defaults -> vsync high exactly vpos 490..491 (1600 clocks), vblank 1 for vpos 480..524.
REQ-040 pix_en alternating 1/0 -> counters advance every second clock, line period 1600 clocks, line_start one clock wide, never high while pix_en=0.
REQ-041 reset asserted one clock at hpos=300, vpos=100 -> next edge hpos=799, vpos=524, syncs inactive, display_on=0; following pix_en edge frame_start=1, frame_count=0.
REQ-042 H=4/1/1/1, V=3/1/1/1, FRAME_W=2, CNT_W=3 -> frame = 42 advances; frame_count sequence 0,1,2,3,0 over 5 frames.
